// File: rtl/hpb_wr_sched.sv
// hpb_wr_sched: shares the single HPB write port between the feed-decoder
// price-update path and the host configuration path.
//
// It runs the request/grant/release write-window handshake with tts.
// Feed has priority. After a run of feed accepts while host waits,
// host is forced a slot.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   feed_wr_*         feed write request (valid/ready/addr/data)
//   host_wr_*         host write request (valid/ready/addr/data)
//   hpb_wr_req/gnt    write-window request to / grant from tts
//   hpb_wr_en/addr/   registered HPB write strobe, address and data
//   hpb_wr_data
//   rcb_wr_done       tts pulse: window closed, read side resynced
//   busy              scheduler not idle
//
// Optional macro HPB_WR_STATS_EN adds the feed_wr_cnt, host_wr_cnt and
// win_cnt outputs.
module hpb_wr_sched #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 64,
    parameter int WINDOW_MAX     = 16,
    parameter int FEED_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              feed_wr_valid,
    output logic              feed_wr_ready,
    input  logic [ADDR_W-1:0] feed_wr_addr,
    input  logic [DATA_W-1:0] feed_wr_data,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              hpb_wr_req,
    input  logic              hpb_wr_gnt,
    output logic              hpb_wr_en,
    output logic [ADDR_W-1:0] hpb_wr_addr,
    output logic [DATA_W-1:0] hpb_wr_data,
    input  logic              rcb_wr_done,
    output logic              busy
`ifdef HPB_WR_STATS_EN
    ,
    output logic [31:0]       feed_wr_cnt,
    output logic [31:0]       host_wr_cnt,
    output logic [31:0]       win_cnt
`endif
);

    localparam int WIN_W = $clog2(WINDOW_MAX + 1);
    localparam int STV_W = $clog2(FEED_BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        RELEASE
    } state_t;

    state_t            state;
    logic [WIN_W-1:0]  win_q;
    logic [STV_W-1:0]  starve_q;
    logic              rel_first;

    logic host_sel;
    logic feed_sel;
    logic slot_open;
    logic feed_acc;
    logic host_acc;
    logic any_acc;
    logic no_valid;
    logic win_last;

    // Host takes the slot when feed is idle or feed used up its burst.
    assign host_sel  = host_wr_valid &&
                       (!feed_wr_valid ||
                        starve_q == STV_W'(FEED_BURST_MAX));
    assign feed_sel  = feed_wr_valid && !host_sel;

    // A reset cycle never accepts: nothing accepted there could be emitted.
    assign slot_open = (state == WRITE) && hpb_wr_gnt && !reset;

    assign feed_wr_ready = slot_open && feed_sel;
    assign host_wr_ready = slot_open && host_sel;

    assign feed_acc = feed_wr_valid && feed_wr_ready;
    assign host_acc = host_wr_valid && host_wr_ready;
    assign any_acc  = feed_acc || host_acc;
    assign no_valid = !feed_wr_valid && !host_wr_valid;
    assign win_last = win_q == WIN_W'(WINDOW_MAX - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hpb_wr_req  <= 1'b0;
            busy        <= 1'b0;
            hpb_wr_en   <= 1'b0;
            hpb_wr_addr <= '0;
            hpb_wr_data <= '0;
            win_q       <= '0;
            starve_q    <= '0;
            rel_first   <= 1'b0;
        end else begin
            hpb_wr_en <= any_acc;
            if (feed_acc) begin
                hpb_wr_addr <= feed_wr_addr;
                hpb_wr_data <= feed_wr_data;
            end else if (host_acc) begin
                hpb_wr_addr <= host_wr_addr;
                hpb_wr_data <= host_wr_data;
            end

            if (host_acc || !host_wr_valid) begin
                starve_q <= '0;
            end else if (feed_acc) begin
                starve_q <= starve_q + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!no_valid) begin
                        state      <= REQ;
                        hpb_wr_req <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                REQ: begin
                    if (hpb_wr_gnt) begin
                        state <= WRITE;
                        win_q <= '0;
                    end
                end
                WRITE: begin
                    // Grant loss keeps req high and re-requests.
                    if (!hpb_wr_gnt) begin
                        state <= REQ;
                    end else if (no_valid || (any_acc && win_last)) begin
                        state      <= RELEASE;
                        hpb_wr_req <= 1'b0;
                        rel_first  <= 1'b1;
                    end else if (any_acc) begin
                        win_q <= win_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // The last strobe drains in the first RELEASE
                    // cycle, so done only counts from the second.
                    rel_first <= 1'b0;
                    if (!rel_first && rcb_wr_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef HPB_WR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            feed_wr_cnt <= '0;
            host_wr_cnt <= '0;
            win_cnt     <= '0;
        end else begin
            if (feed_acc) begin
                feed_wr_cnt <= feed_wr_cnt + 32'd1;
            end
            if (host_acc) begin
                host_wr_cnt <= host_wr_cnt + 32'd1;
            end
            if (state == REQ && hpb_wr_gnt) begin
                win_cnt <= win_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hpb_wr_sched.sv
// tb_hpb_wr_sched: directed and randomized bench for hpb_wr_sched.
// A window-level reference model predicts every output each cycle.
module tb_hpb_wr_sched;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int WM = 8;
    localparam int FB = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          feed_wr_valid = 1'b0;
    logic          feed_wr_ready;
    logic [AW-1:0] feed_wr_addr = '0;
    logic [DW-1:0] feed_wr_data = '0;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          hpb_wr_req;
    logic          hpb_wr_gnt = 1'b0;
    logic          hpb_wr_en;
    logic [AW-1:0] hpb_wr_addr;
    logic [DW-1:0] hpb_wr_data;
    logic          rcb_wr_done = 1'b0;
    logic          busy;
`ifdef HPB_WR_STATS_EN
    logic [31:0]   feed_wr_cnt;
    logic [31:0]   host_wr_cnt;
    logic [31:0]   win_cnt;
`endif

    hpb_wr_sched #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .WINDOW_MAX(WM),
        .FEED_BURST_MAX(FB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .feed_wr_valid(feed_wr_valid),
        .feed_wr_ready(feed_wr_ready),
        .feed_wr_addr(feed_wr_addr),
        .feed_wr_data(feed_wr_data),
        .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data),
        .hpb_wr_req(hpb_wr_req),
        .hpb_wr_gnt(hpb_wr_gnt),
        .hpb_wr_en(hpb_wr_en),
        .hpb_wr_addr(hpb_wr_addr),
        .hpb_wr_data(hpb_wr_data),
        .rcb_wr_done(rcb_wr_done),
        .busy(busy)
`ifdef HPB_WR_STATS_EN
        ,
        .feed_wr_cnt(feed_wr_cnt),
        .host_wr_cnt(host_wr_cnt),
        .win_cnt(win_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp,
                     $time);
        end
    endtask

    // Requester queues; fronts are presented and held until accepted.
    wr_t feed_q[$];
    wr_t host_q[$];
    wr_t log_q[$];
    int  win_sizes[$];
    int  cur_win = 0;
    logic prev_busy = 1'b0;
    logic f_acc = 1'b0;
    logic h_acc = 1'b0;
    int  acc_total = 0;

    task automatic push_f(input logic [AW-1:0] a, input logic [DW-1:0] d);
        feed_q.push_back({a, d});
    endtask

    task automatic push_h(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_q.push_back({a, d});
    endtask

    always @(posedge clk) begin
        #1;
        if (f_acc && feed_q.size() > 0) feed_q.delete(0);
        if (h_acc && host_q.size() > 0) host_q.delete(0);
        feed_wr_valid = feed_q.size() > 0;
        host_wr_valid = host_q.size() > 0;
        if (feed_wr_valid) begin
            feed_wr_addr = feed_q[0].a;
            feed_wr_data = feed_q[0].d;
        end
        if (host_wr_valid) begin
            host_wr_addr = host_q[0].a;
            host_wr_data = host_q[0].d;
        end
    end

    // tts responder: grants after a delay, may drop grant, pulses done.
    logic tts_auto = 1'b1;
    logic rnd_mode = 1'b0;
    int   gnt_delay = 0;
    int   gnt_wait = 0;
    int   done_delay = 0;
    int   done_wait = 0;
    int   drop_left = 0;

    always @(posedge clk) begin
        #1;
        if (tts_auto) begin
            rcb_wr_done = 1'b0;
            if (hpb_wr_req) begin
                done_wait = 0;
                if (rnd_mode && $urandom_range(0, 9) == 0)
                    rcb_wr_done = 1'b1;
                if (drop_left > 0) begin
                    hpb_wr_gnt = 1'b0;
                    drop_left--;
                    gnt_wait = gnt_delay;
                end else if (!hpb_wr_gnt) begin
                    if (gnt_wait >= gnt_delay) begin
                        hpb_wr_gnt = 1'b1;
                        gnt_wait = 0;
                        if (rnd_mode) gnt_delay = int'($urandom_range(0, 3));
                    end else begin
                        gnt_wait++;
                    end
                end else if (rnd_mode && $urandom_range(0, 24) == 0) begin
                    drop_left = int'($urandom_range(1, 3));
                end
            end else begin
                hpb_wr_gnt = 1'b0;
                gnt_wait = 0;
                if (busy) begin
                    if (done_wait >= done_delay) begin
                        rcb_wr_done = 1'b1;
                        done_wait = 0;
                        if (rnd_mode) done_delay = int'($urandom_range(0, 3));
                    end else begin
                        done_wait++;
                    end
                end else begin
                    done_wait = 0;
                    if (rnd_mode && $urandom_range(0, 9) == 0)
                        rcb_wr_done = 1'b1;
                end
            end
        end
    end

    // Reference model. Phase: 0 idle, 1 awaiting grant, 2 window open,
    // 3 closing. Outputs are predicted from phase and the write history.
    int            m_phase = 0;
    int            m_age = 0;
    int            m_win = 0;
    int            m_starve = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_init = 1'b0;
    logic          host_turn;
    logic          e_open;
    logic          e_fr;
    logic          e_hr;

    always @(negedge clk) begin
        host_turn = host_wr_valid && (!feed_wr_valid || m_starve >= FB);
        e_open = (m_phase == 2) && hpb_wr_gnt && !reset;
        e_fr = e_open && feed_wr_valid && !host_turn;
        e_hr = e_open && host_turn;
        if (m_init) begin
            chk("feed_ready", feed_wr_ready, e_fr);
            chk("host_ready", host_wr_ready, e_hr);
            chk("req", hpb_wr_req, m_phase == 1 || m_phase == 2);
            chk("busy", busy, m_phase != 0);
            chk("en", hpb_wr_en, m_en);
            chk("addr", hpb_wr_addr, m_addr);
            chk("data", hpb_wr_data, m_data);
            if (hpb_wr_en) begin
                log_q.push_back({hpb_wr_addr, hpb_wr_data});
                cur_win++;
            end
            if (prev_busy && !busy) begin
                win_sizes.push_back(cur_win);
                cur_win = 0;
            end
        end
        prev_busy = busy;
        f_acc = feed_wr_valid && feed_wr_ready;
        h_acc = host_wr_valid && host_wr_ready;
        if (f_acc || h_acc) acc_total++;

        if (reset) begin
            m_phase = 0;
            m_age = 0;
            m_win = 0;
            m_starve = 0;
            m_en = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_init = 1'b1;
        end else begin
            m_en = e_fr || e_hr;
            if (e_fr) begin
                m_addr = feed_wr_addr;
                m_data = feed_wr_data;
            end else if (e_hr) begin
                m_addr = host_wr_addr;
                m_data = host_wr_data;
            end
            if (e_hr || !host_wr_valid) m_starve = 0;
            else if (e_fr) m_starve++;
            case (m_phase)
                0: if (feed_wr_valid || host_wr_valid) m_phase = 1;
                1: if (hpb_wr_gnt) begin
                    m_phase = 2;
                    m_win = 0;
                end
                2: if (!hpb_wr_gnt) begin
                    m_phase = 1;
                end else if (!feed_wr_valid && !host_wr_valid) begin
                    m_phase = 3;
                    m_age = 0;
                end else if (m_en) begin
                    m_win++;
                    if (m_win == WM) begin
                        m_phase = 3;
                        m_age = 0;
                    end
                end
                default: begin
                    if (m_age >= 1 && rcb_wr_done) m_phase = 0;
                    m_age++;
                end
            endcase
        end
    end

    task automatic wait_idle(input int lim, input string name);
        int n = 0;
        while (!(feed_q.size() == 0 && host_q.size() == 0 &&
                 !feed_wr_valid && !host_wr_valid && !busy) && n < lim) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= lim) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy=%0b exp=0", name, busy);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        feed_q.delete();
        host_q.delete();
        feed_wr_valid = 1'b0;
        host_wr_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
    endtask

    logic [AW-1:0] s2_exp [7];
    int            base;
    int            npush;
    int            n;

    initial begin
        s2_exp = '{10'h100, 10'h101, 10'h102, 10'h103,
                   10'h200, 10'h104, 10'h105};
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req", hpb_wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", hpb_wr_en, 0);
        chk("rst_addr", hpb_wr_addr, 0);

        // Single feed write, grant two cycles after request.
        gnt_delay = 2;
        done_delay = 1;
        log_q.delete();
        push_f(10'h012, 64'hAB);
        wait_idle(100, "s1");
        chk("s1_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("s1_addr", log_q[0].a, 10'h012);
            chk("s1_data", log_q[0].d, 64'hAB);
        end

        // Feed burst with a waiting host.
        do_reset();
        gnt_delay = 0;
        log_q.delete();
        for (int i = 0; i < 6; i++)
            push_f(AW'(10'h100 + i), DW'(64'hF0 + i));
        push_h(10'h200, 64'hCAFE);
        wait_idle(100, "s2");
        chk("s2_count", log_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < log_q.size()) chk("s2_order", log_q[i].a, s2_exp[i]);
`ifdef HPB_WR_STATS_EN
        chk("s2_feed_cnt", feed_wr_cnt, 6);
        chk("s2_host_cnt", host_wr_cnt, 1);
        chk("s2_win_cnt", win_cnt, 1);
`endif

        // Ten feed writes split over two windows.
        log_q.delete();
        win_sizes.delete();
        cur_win = 0;
        for (int i = 0; i < 10; i++)
            push_f(AW'(10'h300 + i), DW'(i));
        wait_idle(200, "s3");
        chk("s3_count", log_q.size(), 10);
        chk("s3_windows", win_sizes.size(), 2);
        if (win_sizes.size() == 2) begin
            chk("s3_win0", win_sizes[0], 8);
            chk("s3_win1", win_sizes[1], 2);
        end

        // Grant dropped for three cycles after the second accept.
        log_q.delete();
        base = acc_total;
        for (int i = 0; i < 5; i++)
            push_f(AW'(10'h040 + i), DW'(64'h500 + i));
        n = 0;
        while (acc_total < base + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s4_two_acc", acc_total - base, 2);
        drop_left = 3;
        wait_idle(200, "s4");
        chk("s4_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) chk("s4_order", log_q[i].a, AW'(10'h040 + i));

        // Reset in the middle of a window with writes pending.
        log_q.delete();
        base = acc_total;
        for (int i = 0; i < 6; i++)
            push_f(AW'(10'h060 + i), DW'(i));
        n = 0;
        while (acc_total < base + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s5_two_acc", acc_total - base, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tts_auto = 1'b0;
        hpb_wr_gnt = 1'b0;
        rcb_wr_done = 1'b0;
        feed_q.delete();
        feed_wr_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("s5_req", hpb_wr_req, 0);
        chk("s5_en", hpb_wr_en, 0);
        chk("s5_busy", busy, 0);
        chk("s5_addr", hpb_wr_addr, 0);
        @(posedge clk);
        #2;
        rcb_wr_done = 1'b1;
        @(posedge clk);
        #2;
        rcb_wr_done = 1'b0;
        @(negedge clk);
        #1;
        chk("s5_idle_done", busy, 0);
        push_f(10'h077, 64'h77);
        n = 0;
        while (!hpb_wr_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s5_in_req", hpb_wr_req, 1);
        @(posedge clk);
        #2;
        rcb_wr_done = 1'b1;
        @(posedge clk);
        #2;
        rcb_wr_done = 1'b0;
        @(negedge clk);
        #1;
        chk("s5_req_done_req", hpb_wr_req, 1);
        chk("s5_req_done_busy", busy, 1);
        tts_auto = 1'b1;
        wait_idle(100, "s5");

        // Randomized traffic with random grant/done timing and drops.
        log_q.delete();
        npush = 0;
        rnd_mode = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            #1;
            if (feed_q.size() < 10 && $urandom_range(0, 2) == 0) begin
                push_f(AW'($urandom), {$urandom, $urandom});
                npush++;
            end
            if (host_q.size() < 4 && $urandom_range(0, 6) == 0) begin
                push_h(AW'($urandom), {$urandom, $urandom});
                npush++;
            end
        end
        rnd_mode = 1'b0;
        wait_idle(1000, "rnd");
        chk("rnd_count", log_q.size(), npush);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpb_wr_sched.md
Name: hpb_wr_sched

Overview:
- Write scheduler for the strategy block's host price book (HPB).
- Shares the single HPB write port between two requesters:
  - the feed-decoder price-update path (feed);
  - the host configuration path (host).
- Runs the strategy's write-window handshake: request (hpb_wr_req), grant (hpb_wr_gnt), release acknowledged by rcb_wr_done.
- Sits between the feed decoder / host CSR logic and tts.

Parameters:
- ADDR_W, 10: HPB address width.
- DATA_W, 64: HPB entry width.
- WINDOW_MAX, 16: maximum writes accepted per granted window, >=1.
- FEED_BURST_MAX, 4: consecutive feed accepts allowed while host is pending before host is forced a slot, >=1.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- feed_wr_valid  in  1  feed write request valid.
- feed_wr_ready  out  1  feed write accepted this cycle (valid & ready).
- feed_wr_addr  in  ADDR_W  feed write address.
- feed_wr_data  in  DATA_W  feed write data.
- host_wr_valid  in  1  host write request valid.
- host_wr_ready  out  1  host write accepted this cycle.
- host_wr_addr  in  ADDR_W  host write address.
- host_wr_data  in  DATA_W  host write data.
- hpb_wr_req  out  1  requests the HPB write window from tts.
- hpb_wr_gnt  in  1  tts grants the window (level).
- hpb_wr_en  out  1  HPB write strobe.
- hpb_wr_addr  out  ADDR_W  HPB write address.
- hpb_wr_data  out  DATA_W  HPB write data.
- rcb_wr_done  in  1  tts pulse: window closed, read side resynced.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high.
- Reset:
  - state=IDLE.
  - hpb_wr_req, hpb_wr_en, busy, feed_wr_ready, host_wr_ready = 0.
  - hpb_wr_addr, hpb_wr_data = 0.
  - window and starve counters = 0.
  - Reset asserted mid-window drops hpb_wr_req the next cycle. No pending write is emitted.
- FSM states: IDLE, REQ, WRITE, RELEASE. hpb_wr_req is registered and high in REQ and WRITE.
- IDLE: feed_wr_valid|host_wr_valid -> REQ.
- REQ: wait for hpb_wr_gnt=1 -> WRITE; window counter cleared.
- WRITE, acceptance:
  - Only when hpb_wr_gnt=1 is exactly one requester selected; its ready is asserted combinationally.
  - An accept is valid & ready.
  - hpb_wr_en/addr/data are registered: asserted the cycle after the accept with the accepted addr/data.
  - Throughput: 1 write/cycle.
- WRITE, grant drop: hpb_wr_gnt=0 -> both readys 0 that cycle -> REQ (req stays high). No accept is lost or duplicated.
- WRITE exit to RELEASE when either:
  - neither valid is high; or
  - the accept making window count == WINDOW_MAX occurs (transition next cycle).
- RELEASE:
  - hpb_wr_req=0.
  - The final hpb_wr_en occurs in the first RELEASE cycle.
  - rcb_wr_done is sampled only in RELEASE, from its second cycle onward -> IDLE.
  - rcb_wr_done in any other state or cycle is ignored.
- Arbitration:
  - Feed has priority.
  - Starve counter increments on each feed accept while host_wr_valid=1.
  - It clears on host accept or when host_wr_valid=0.
  - When starve count == FEED_BURST_MAX and host_wr_valid=1, the next slot goes to host.
  - Host is selected whenever feed_wr_valid=0.
- Outside WRITE: readys=0. Requesters must hold valid/addr/data stable until accepted.
- hpb_wr_addr/data hold their last value when hpb_wr_en=0.

Optional Feature:
- Macro: HPB_WR_STATS_EN.
- Defined: adds outputs feed_wr_cnt[31:0], host_wr_cnt[31:0], win_cnt[31:0].
  - feed_wr_cnt / host_wr_cnt increment on each accept of that requester.
  - win_cnt increments on each REQ->WRITE transition.
  - All wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single feed write (addr 0x012, data 0xAB), gnt raised 2 cycles after req:
  - one hpb_wr_en with 0x012/0xAB, 1 cycle after accept;
  - then req=0;
  - then IDLE one cycle after rcb_wr_done.
- FEED_BURST_MAX=4; feed holds 6 queued writes and host 1 write, both valid from the same cycle:
  - HPB write order F0 F1 F2 F3 H0 F4 F5, all in one window.
- WINDOW_MAX=8, 10 feed writes:
  - 8 writes, RELEASE, done, new req, 2 writes;
  - 10 distinct hpb_wr_en total.
- Grant dropped for 3 cycles after the 2nd accept of 5:
  - readys 0 during the drop; req stays 1;
  - on regrant the remaining 3 are written;
  - exactly 5 en, no duplicates.
- Reset asserted in WRITE with writes pending:
  - next cycle all outputs 0 and state IDLE;
  - rcb_wr_done pulsed in IDLE or REQ causes no state change.
- With HPB_WR_STATS_EN, after scenario 2:
  - feed_wr_cnt=6, host_wr_cnt=1, win_cnt=1.
